// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage: 32-bit loads/stores to a 16-bit async SRAM as two half-word accesses (LO then HI).
// Latency: a request seen in IDLE at cycle t completes (ready=1) at cycle t+3+2*WAIT_CYCLES.
// Backpressure: ready is held low while an access is in flight, freezing the pipeline upstream.
// Optional: define MEM_STALL_CNT_EN to add stall_cnt/stall_cnt_clr (count of ready=0 cycles).

module mem_stage_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,        // extra cycles per half-word, 1..15
  parameter logic [31:0] BASE_ADDR   = 32'd1024  // byte address of SRAM half-word 0
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] ST_Val,
  output logic        ready,
  output logic [31:0] MEM_Result,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_OUT,
  output logic        SRAM_DQ_OE,
  input  logic [15:0] SRAM_DQ_IN,
  output logic        SRAM_WE_N
`ifdef MEM_STALL_CNT_EN
  ,
  input  logic        stall_cnt_clr,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Counter value on the last cycle of a half-word phase.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        is_read;
  logic        is_read_nxt;
  logic        req;
  logic        phase_end;
  logic [16:0] word;
  logic        sample_lo;
  logic        sample_hi;

  // A simultaneous read+write request is treated as a read.
  assign req       = MEM_R_EN | MEM_W_EN;
  assign phase_end = (cnt == WAIT_LAST);

  // Word index relative to the SRAM window; wraps for addresses below BASE_ADDR,
  // and the byte offset within the word is dropped.
  assign word = 17'((ALU_Res - BASE_ADDR) >> 2);

  // State, phase counter and latched access type.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      is_read <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      is_read <= is_read_nxt;
    end
  end

  // Next-state, counter and SRAM/pipeline outputs; address and store data track inputs live.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    is_read_nxt = is_read;
    ready       = 1'b0;
    SRAM_ADDR   = 18'd0;
    SRAM_DQ_OUT = 16'd0;
    SRAM_DQ_OE  = 1'b0;
    SRAM_WE_N   = 1'b1;
    sample_lo   = 1'b0;
    sample_hi   = 1'b0;

    case (state)
      ST_IDLE: begin
        ready = ~req;
        if (req) begin
          state_nxt   = ST_LO;
          cnt_nxt     = 4'd0;
          is_read_nxt = MEM_R_EN;
        end
      end

      ST_LO: begin
        SRAM_ADDR = {word, 1'b0};
        if (!is_read) begin
          SRAM_DQ_OE  = 1'b1;
          SRAM_DQ_OUT = ST_Val[15:0];
          // WE_N rises on the last cycle so address/data are stable at the write edge.
          SRAM_WE_N   = phase_end;
        end
        if (phase_end) begin
          state_nxt = ST_HI;
          cnt_nxt   = 4'd0;
          sample_lo = is_read;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end

      ST_HI: begin
        SRAM_ADDR = {word, 1'b1};
        if (!is_read) begin
          SRAM_DQ_OE  = 1'b1;
          SRAM_DQ_OUT = ST_Val[31:16];
          SRAM_WE_N   = phase_end;
        end
        if (phase_end) begin
          state_nxt = ST_DONE;
          cnt_nxt   = 4'd0;
          sample_hi = is_read;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end

      ST_DONE: begin
        ready     = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Load result: each half captured on the last cycle of its phase; stores leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MEM_Result <= 32'd0;
    end else begin
      if (sample_lo) MEM_Result[15:0]  <= SRAM_DQ_IN;
      if (sample_hi) MEM_Result[31:16] <= SRAM_DQ_IN;
    end
  end

`ifdef MEM_STALL_CNT_EN
  // Freeze-cycle counter; a clear in the same cycle beats the increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
    end else if (stall_cnt_clr) begin
      stall_cnt <= 32'd0;
    end else if (!ready) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Testbench for mem_stage_sram_ctrl: word-level reference memory plus a 16-bit SRAM device model.
// Each access is checked cycle by cycle against the expected LO/HI phase schedule.
// Randomized loads/stores/idle gaps follow a directed opening sequence.

module tb_mem_stage_sram_ctrl;

  localparam int          W    = 1;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          LAT  = 3 + 2 * W;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r_en = 1'b0;
  logic        w_en = 1'b0;
  logic [31:0] alu_res = 32'd0;
  logic [31:0] st_val = 32'd0;
  logic        ready;
  logic [31:0] mem_result;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
`ifdef MEM_STALL_CNT_EN
  logic        stall_cnt_clr = 1'b0;
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_result = 32'd0;
  logic [31:0] ref_mem [int];
  logic [31:0] st_addrs [$];
  logic [15:0] sram [0:262143];

  mem_stage_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (r_en),
    .MEM_W_EN   (w_en),
    .ALU_Res    (alu_res),
    .ST_Val     (st_val),
    .ready      (ready),
    .MEM_Result (mem_result),
    .SRAM_ADDR  (sram_addr),
    .SRAM_DQ_OUT(sram_dq_out),
    .SRAM_DQ_OE (sram_dq_oe),
    .SRAM_DQ_IN (sram_dq_in),
    .SRAM_WE_N  (sram_we_n)
`ifdef MEM_STALL_CNT_EN
    ,
    .stall_cnt_clr(stall_cnt_clr),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: read data follows the address, writes land while WE_N is low.
  assign sram_dq_in = sram[sram_addr];
  always @(negedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram[sram_addr] = sram_dq_out;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Current cycle is IDLE with the request already driven; follow it to DONE.
  task automatic run_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    bit          is_wr;
    int          word;
    int          ph;
    int          wi;
    logic [31:0] ea;
    is_wr = wr && !rd;
    word  = int'(((a - BASE) >> 2) % 32'd131072);
    chk("req_ready", ready, 0);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      chk("ready_sched", ready, (k == LAT) ? 1 : 0);
      if (k < LAT) begin
        ph = (k - 1) / (W + 1);
        wi = (k - 1) % (W + 1);
        ea = 32'(word * 2 + ph);
        chk("addr", sram_addr, ea);
        chk("oe", sram_dq_oe, is_wr ? 1 : 0);
        chk("we_n", sram_we_n, (is_wr && wi < W) ? 0 : 1);
        if (is_wr) chk("dq_out", sram_dq_out, ph ? d[31:16] : d[15:0]);
      end else begin
        chk("done_addr", sram_addr, 0);
        chk("done_we_n", sram_we_n, 1);
        if (rd) exp_result = ref_mem.exists(word) ? ref_mem[word] : 32'hxxxxxxxx;
        if (is_wr) begin
          ref_mem[word] = d;
          st_addrs.push_back(a);
        end
        chk("result", mem_result, exp_result);
      end
    end
  endtask

  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    r_en = rd; w_en = wr; alu_res = a; st_val = d;
    #1;
    run_access(rd, wr, a, d);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      r_en = 1'b0; w_en = 1'b0; alu_res = $urandom(); st_val = $urandom();
      #1;
      chk("idle_ready", ready, 1);
      chk("idle_we_n", sram_we_n, 1);
      chk("idle_oe", sram_dq_oe, 0);
      chk("idle_addr", sram_addr, 0);
      chk("idle_result", mem_result, exp_result);
    end
  endtask

  function automatic logic [31:0] pick_load_addr();
    return st_addrs[$urandom_range(0, st_addrs.size() - 1)];
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          op;

    // Reset state
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe", sram_dq_oe, 0);
    chk("rst_result", mem_result, 0);
    chk("rst_addr", sram_addr, 0);
`ifdef MEM_STALL_CNT_EN
    chk("rst_stall", stall_cnt, 0);
`endif
    #1 rst = 1'b1;

    // Store then load of the same word, then non-memory cycles holding the result
    do_access(1'b0, 1'b1, 32'h408, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 32'h408, 32'h0);
    chk("load_deadbeef", mem_result, 32'hDEADBEEF);
    idle_cycles(10);

    // Back-to-back load then store, then a both-enables access behaving as a load
    do_access(1'b1, 1'b0, 32'h408, 32'h0);
    do_access(1'b0, 1'b1, 32'h40C, 32'h12345678);
    do_access(1'b1, 1'b1, 32'h40E, 32'hFFFF0000);
    chk("both_en_load", mem_result, 32'h12345678);
    idle_cycles(2);

    // Asynchronous reset during the HI phase of a store, request held through release
    @(posedge clk); #1;
    a = BASE + 32'h40; d = 32'hCAFEF00D;
    r_en = 1'b0; w_en = 1'b1; alu_res = a; st_val = d;
    repeat (3) @(posedge clk);
    #1;
    chk("hi_we_n_pre", sram_we_n, 0);
    #2 rst = 1'b0;
    #1;
    exp_result = 32'd0;
    chk("arst_we_n", sram_we_n, 1);
    chk("arst_oe", sram_dq_oe, 0);
    chk("arst_result", mem_result, 0);
    chk("arst_addr", sram_addr, 0);
`ifdef MEM_STALL_CNT_EN
    chk("arst_stall", stall_cnt, 0);
`endif
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    run_access(1'b0, 1'b1, a, d);
`ifdef MEM_STALL_CNT_EN
    chk("stall_after", stall_cnt, 5);
`endif
    idle_cycles(1);

`ifdef MEM_STALL_CNT_EN
    // Clear asserted on a freeze cycle wins over the increment
    @(posedge clk); #1;
    a = BASE + 32'h80; d = 32'h0BADC0DE;
    r_en = 1'b0; w_en = 1'b1; alu_res = a; st_val = d; stall_cnt_clr = 1'b1;
    @(posedge clk); #1;
    stall_cnt_clr = 1'b0;
    chk("clr_wins", stall_cnt, 0);
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("clr_ready", ready, 1);
    chk("clr_count", stall_cnt, 4);
    ref_mem[int'(((a - BASE) >> 2) % 32'd131072)] = d;
    st_addrs.push_back(a);
    idle_cycles(1);
`endif

    // Randomized mix: stores (in-window and anywhere), loads, dual-enable loads, idle gaps
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 4);
      d  = $urandom();
      case (op)
        0: do_access(1'b0, 1'b1, BASE + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3), d);
        1: do_access(1'b0, 1'b1, $urandom(), d);
        2: do_access(1'b1, 1'b0, pick_load_addr(), d);
        3: do_access(1'b1, 1'b1, pick_load_addr(), d);
        default: idle_cycles($urandom_range(1, 3));
      endcase
    end
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
